// File: rtl/fetch_pkg.sv
// Shared widths, FSM states and queue entry type for the instruction fetch queue.
package fetch_pkg;
  localparam int DEFAULT_ADDR_W = 64;
  localparam int DEFAULT_INST_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] pc;
    logic [DEFAULT_INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_queue_if.sv
// Instruction-memory request/response and decode-side handshake bundle.
// master = fetch stage, slave = memory plus decode environment.
interface inst_fetch_queue_if #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
);
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// First-word-fall-through FIFO with synchronous clear; head reads as zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output entry_t           head
);
  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: one outstanding imem read, results queued with their PC for decode.
// Optional same-cycle bypass of an empty queue when FETCH_BYPASS_EN is defined.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int INST_W = DEFAULT_INST_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_w,
  input  logic              flush,
  inst_fetch_queue_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [CNT_W-1:0]  count;
  entry_t            head, push_data;
  logic              push, pop, fifo_valid, req_hs, bypass;

  assign fifo_valid = (count != '0);
  assign push_data  = '{pc: req_pc_q, inst: bus.imem_rsp_data};

  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    push     = 1'b0;
    bypass   = 1'b0;
    // Gated by reset so the request is quiet while the block is held in reset.
    bus.imem_req_valid = reset && (state_q == IDLE) && (count != CNT_W'(DEPTH)) && !flush;
    bus.imem_req_addr  = pc;
    req_hs = bus.imem_req_valid && bus.imem_req_ready;
    pc_w   = req_hs;
`ifdef FETCH_BYPASS_EN
    bypass = (state_q == WAIT) && bus.imem_rsp_valid && !fifo_valid && bus.inst_ready && !flush;
`endif
    case (state_q)
      IDLE: begin
        if (req_hs) begin
          req_pc_d = pc;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_rsp_valid) begin
          push    = !flush && !bypass;
          state_d = IDLE;
        end else if (flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (bus.imem_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  assign pop = fifo_valid && bus.inst_ready && !flush;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .clear     (flush),
    .count     (count),
    .head      (head)
  );

  assign bus.inst_valid = fifo_valid || bypass;
  assign bus.inst       = bypass ? bus.imem_rsp_data : head.inst;
  assign bus.inst_pc    = bypass ? req_pc_q : head.pc;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus a randomized
// run against a queue-based reference model. Honours FETCH_BYPASS_EN if defined.
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc;
  logic        pc_w;
  logic        flush;
  int          tests_run = 0;
  int          tests_failed = 0;
  int          pcw_count = 0;

  inst_fetch_queue_if #(.ADDR_W(64), .INST_W(32)) bus ();

  inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(64), .INST_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .pc    (pc),
    .pc_w  (pc_w),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (pc_w === 1'b1) pcw_count++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic fetch_one(input logic [63:0] addr, input logic [31:0] data);
    @(posedge clk); #1 pc = addr; bus.imem_req_ready = 1'b1;
    @(posedge clk); #1 bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = data;
    @(posedge clk); #1 bus.imem_rsp_valid = 1'b0;
  endtask

  task automatic drain();
    @(posedge clk); #1 bus.imem_req_ready = 1'b0; bus.inst_ready = 1'b1;
    repeat (DEPTH + 1) @(posedge clk);
    #1 bus.inst_ready = 1'b0;
  endtask

  task automatic test_reset();
    int base;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++; if (pc_w !== 1'b0) begin tests_failed++; $display("FAIL reset_pcw: got %b want 0", pc_w); end
    tests_run++; if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
    tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_inst_valid: got %b want 0", bus.inst_valid); end
    tests_run++; if (bus.inst !== 32'h0) begin tests_failed++; $display("FAIL reset_inst: got %h want 0", bus.inst); end
    tests_run++; if (bus.inst_pc !== 64'h0) begin tests_failed++; $display("FAIL reset_inst_pc: got %h want 0", bus.inst_pc); end
    @(posedge clk); #1 reset = 1'b1; pc = 64'h100; bus.imem_req_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (pc_w !== 1'b1) begin tests_failed++; $display("FAIL reset_first_hs: got %b want 1", pc_w); end
    @(posedge clk); #1 bus.imem_req_ready = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_wait_req: got %b want 0", bus.imem_req_valid); end
    #1 reset = 1'b0;
    #1;
    tests_run++; if ({pc_w, bus.imem_req_valid, bus.inst_valid} !== 3'b000) begin tests_failed++; $display("FAIL reset_midwait: got %b want 000", {pc_w, bus.imem_req_valid, bus.inst_valid}); end
    @(posedge clk); #1 reset = 1'b1; base = pcw_count;
    repeat (3) begin
      @(negedge clk);
      tests_run++; if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL reset_idle_req: got %b want 1", bus.imem_req_valid); end
    end
    @(posedge clk); #1;
    tests_run++; if (pcw_count - base !== 0) begin tests_failed++; $display("FAIL reset_no_pcw: got %0d pulses want 0", pcw_count - base); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic_fetch();
    int base;
    base = pcw_count;
    @(posedge clk); #1 pc = 64'h1000; bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b0;
    @(negedge clk);
    tests_run++; if (pc_w !== 1'b1) begin tests_failed++; $display("FAIL basic_pcw: got %b want 1", pc_w); end
    tests_run++; if (bus.imem_req_addr !== 64'h1000) begin tests_failed++; $display("FAIL basic_addr: got %h want 1000", bus.imem_req_addr); end
    @(posedge clk); #1 bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h00A00093; pc = 64'h1004;
    @(negedge clk);
    tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_latency: got %b want 0", bus.inst_valid); end
    @(posedge clk); #1 bus.imem_rsp_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.inst_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid: got %b want 1", bus.inst_valid); end
    tests_run++; if (bus.inst !== 32'h00A00093) begin tests_failed++; $display("FAIL basic_inst: got %h want 00a00093", bus.inst); end
    tests_run++; if (bus.inst_pc !== 64'h1000) begin tests_failed++; $display("FAIL basic_inst_pc: got %h want 1000", bus.inst_pc); end
    @(posedge clk); #1;
    tests_run++; if (pcw_count - base !== 1) begin tests_failed++; $display("FAIL basic_pcw_count: got %0d want 1", pcw_count - base); end
    drain();
    $display("[TB] test_basic_fetch done");
  endtask

  task automatic test_backpressure();
    int base;
    base = pcw_count;
    bus.inst_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) fetch_one(64'(4 * i), 32'hA000_0000 + 32'(i));
    pc = 64'h10; bus.imem_req_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests_run++; if ({bus.imem_req_valid, pc_w} !== 2'b00) begin tests_failed++; $display("FAIL full_req: got %b want 00", {bus.imem_req_valid, pc_w}); end
    end
    @(posedge clk); #1;
    tests_run++; if (pcw_count - base !== DEPTH) begin tests_failed++; $display("FAIL full_pcw_count: got %0d want %0d", pcw_count - base, DEPTH); end
    bus.imem_req_ready = 1'b0; bus.inst_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      tests_run++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 64'(4 * i) || bus.inst !== 32'hA000_0000 + 32'(i))
        begin tests_failed++; $display("FAIL full_pop_%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", i, bus.inst_valid, bus.inst_pc, bus.inst, 64'(4 * i), 32'hA000_0000 + 32'(i)); end
    end
    @(posedge clk); #1 bus.inst_ready = 1'b0; bus.imem_req_ready = 1'b1; pc = 64'h10;
    @(negedge clk);
    tests_run++; if ({bus.inst_valid, pc_w} !== 2'b01) begin tests_failed++; $display("FAIL full_resume: got %b want 01", {bus.inst_valid, pc_w}); end
    @(posedge clk); #1 bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0013;
    @(posedge clk); #1 bus.imem_rsp_valid = 1'b0;
    drain();
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_flush_wait();
    bus.inst_ready = 1'b0;
    @(posedge clk); #1 pc = 64'h20; bus.imem_req_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (pc_w !== 1'b1) begin tests_failed++; $display("FAIL flush_hs: got %b want 1", pc_w); end
    @(posedge clk); #1 bus.imem_req_ready = 1'b0; flush = 1'b1; pc = 64'h80;
    @(negedge clk);
    tests_run++; if ({bus.imem_req_valid, pc_w} !== 2'b00) begin tests_failed++; $display("FAIL flush_req: got %b want 00", {bus.imem_req_valid, pc_w}); end
    @(posedge clk); #1 flush = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEADBEEF;
    @(negedge clk);
    tests_run++; if ({bus.imem_req_valid, bus.inst_valid} !== 2'b00) begin tests_failed++; $display("FAIL flush_drop: got %b want 00", {bus.imem_req_valid, bus.inst_valid}); end
    @(posedge clk); #1 bus.imem_rsp_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_discard: got %b want 0", bus.inst_valid); end
    tests_run++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h80) begin tests_failed++; $display("FAIL flush_next_req: got v=%b addr=%h want v=1 addr=80", bus.imem_req_valid, bus.imem_req_addr); end
    @(posedge clk); #1 bus.imem_req_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (pc_w !== 1'b1) begin tests_failed++; $display("FAIL flush_refetch: got %b want 1", pc_w); end
    @(posedge clk); #1 bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0513;
    @(posedge clk); #1 bus.imem_rsp_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 64'h80 || bus.inst !== 32'h513)
      begin tests_failed++; $display("FAIL flush_refetch_data: got v=%b pc=%h inst=%h want v=1 pc=80 inst=00000513", bus.inst_valid, bus.inst_pc, bus.inst); end
    drain();
    $display("[TB] test_flush_wait done");
  endtask

  task automatic test_simultaneous();
    bus.inst_ready = 1'b0;
    fetch_one(64'h200, 32'h11);
    pc = 64'h204; bus.imem_req_ready = 1'b1;
    @(posedge clk); #1 flush = 1'b1; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h22; bus.inst_ready = 1'b1;
    @(negedge clk);
    tests_run++; if ({pc_w, bus.imem_req_valid} !== 2'b00) begin tests_failed++; $display("FAIL simul_pcw: got %b want 00", {pc_w, bus.imem_req_valid}); end
    @(posedge clk); #1 flush = 1'b0; bus.imem_rsp_valid = 1'b0; bus.inst_ready = 1'b0; bus.imem_req_ready = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL simul_empty: got %b want 0", bus.inst_valid); end
    tests_run++; if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL simul_idle: got %b want 1", bus.imem_req_valid); end
    $display("[TB] test_simultaneous done");
  endtask

  task automatic test_bypass();
    @(posedge clk); #1 pc = 64'h40; bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (pc_w !== 1'b1) begin tests_failed++; $display("FAIL bypass_hs: got %b want 1", pc_w); end
    @(posedge clk); #1 bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h13;
    @(negedge clk);
`ifdef FETCH_BYPASS_EN
    tests_run++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h13 || bus.inst_pc !== 64'h40)
      begin tests_failed++; $display("FAIL bypass_same_cycle: got v=%b inst=%h pc=%h want v=1 inst=13 pc=40", bus.inst_valid, bus.inst, bus.inst_pc); end
`else
    tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL bypass_off_latency: got %b want 0", bus.inst_valid); end
`endif
    @(posedge clk); #1 bus.imem_rsp_valid = 1'b0;
    @(negedge clk);
`ifdef FETCH_BYPASS_EN
    tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL bypass_not_pushed: got %b want 0", bus.inst_valid); end
`else
    tests_run++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h13 || bus.inst_pc !== 64'h40)
      begin tests_failed++; $display("FAIL bypass_off_next: got v=%b inst=%h pc=%h want v=1 inst=13 pc=40", bus.inst_valid, bus.inst, bus.inst_pc); end
`endif
    @(posedge clk); #1 bus.inst_ready = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL bypass_empty_after: got %b want 0", bus.inst_valid); end
    $display("[TB] test_bypass done");
  endtask

  // Reference model: a queue of delivered {pc, inst} pairs and one memory slot
  // holding the outstanding request, its latency and whether a flush orphaned it.
  task automatic test_random(input int n);
    logic [63:0] q_pc[$];
    logic [31:0] q_in[$];
    bit          pend, pend_drop, rsp, exp_req, exp_val, byp;
    int          pend_lat, pops;
    logic [63:0] pend_addr, exp_pc;
    logic [31:0] pend_data, exp_in;
    pend = 1'b0; pend_drop = 1'b0; pend_lat = 0; pops = 0;
    pend_addr = '0; pend_data = '0;
    @(posedge clk); #1 reset = 1'b0; flush = 1'b0; bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.inst_ready = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      pc = {$urandom, $urandom} & ~64'h3;
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.inst_ready     = ($urandom_range(0, 2) != 0);
      flush              = ($urandom_range(0, 15) == 0);
      rsp = pend && (pend_lat == 0);
      bus.imem_rsp_valid = rsp;
      bus.imem_rsp_data  = rsp ? pend_data : $urandom;
      @(negedge clk);
      exp_req = !pend && (q_pc.size() < DEPTH) && !flush;
      byp     = BYP && rsp && !pend_drop && !flush && (q_pc.size() == 0) && bus.inst_ready;
      exp_val = (q_pc.size() > 0) || byp;
      tests_run++; if (bus.imem_req_valid !== exp_req) begin tests_failed++; $display("FAIL rand_req_valid c=%0d: got %b want %b", c, bus.imem_req_valid, exp_req); end
      tests_run++; if (pc_w !== (exp_req && bus.imem_req_ready)) begin tests_failed++; $display("FAIL rand_pcw c=%0d: got %b want %b", c, pc_w, exp_req && bus.imem_req_ready); end
      tests_run++; if (bus.imem_req_addr !== pc) begin tests_failed++; $display("FAIL rand_addr c=%0d: got %h want %h", c, bus.imem_req_addr, pc); end
      tests_run++; if (bus.inst_valid !== exp_val) begin tests_failed++; $display("FAIL rand_inst_valid c=%0d: got %b want %b", c, bus.inst_valid, exp_val); end
      if (exp_val) begin
        exp_pc = byp ? pend_addr : q_pc[0];
        exp_in = byp ? pend_data : q_in[0];
        tests_run++; if (bus.inst_pc !== exp_pc || bus.inst !== exp_in)
          begin tests_failed++; $display("FAIL rand_head c=%0d: got pc=%h inst=%h want pc=%h inst=%h", c, bus.inst_pc, bus.inst, exp_pc, exp_in); end
      end
      if (rsp) pend = 1'b0;
      else if (pend && pend_lat > 0) pend_lat--;
      if (flush) begin
        q_pc.delete(); q_in.delete();
        if (pend) pend_drop = 1'b1;
      end else begin
        if (exp_val && bus.inst_ready && !byp) begin void'(q_pc.pop_front()); void'(q_in.pop_front()); end
        if (exp_val && bus.inst_ready) pops++;
        if (rsp && !pend_drop && !byp) begin q_pc.push_back(pend_addr); q_in.push_back(pend_data); end
      end
      if (exp_req && bus.imem_req_ready) begin
        pend = 1'b1; pend_drop = 1'b0; pend_lat = $urandom_range(0, 2);
        pend_addr = pc; pend_data = $urandom;
      end
    end
    @(posedge clk); #1 flush = 1'b0; bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.inst_ready = 1'b0;
    $display("[TB] test_random done: %0d cycles, %0d instructions consumed", n, pops);
  endtask

  initial begin
    reset = 1'b0; pc = '0; flush = 1'b0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0; bus.inst_ready = 1'b0;
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_flush_wait();
    test_simultaneous();
    test_bypass();
    test_random(3000);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
